// File: rtl/slave_axilite_pkg.sv
// Shared definitions for the slave_axilite AXI-Lite responder: response codes,
// FSM state types and the address range check.
package slave_axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Addresses are zero-extended to this width before comparison so that
  // START + NUM can never wrap for any supported address width.
  localparam int ADDR_EXT_W = 64;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  function automatic logic addr_in_range(input logic [ADDR_EXT_W-1:0] addr,
                                         input logic [ADDR_EXT_W-1:0] start,
                                         input int unsigned           num);
    return (addr >= start) && ((addr - start) < ADDR_EXT_W'(num));
  endfunction

endpackage

// File: rtl/slave_axilite_regfile.sv
// Word register file behind slave_axilite: one synchronous write port, one
// read port registered on capture. Byte enables exist with SLAVE_AXILITE_WSTRB_EN.
module slave_axilite_regfile
  import slave_axilite_pkg::*;
#(
  parameter int NUM   = 16,
  parameter int D_W   = 32,
  parameter int IDX_W = 4
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [D_W-1:0]   wr_data,
`ifdef SLAVE_AXILITE_WSTRB_EN
  input  logic [D_W/8-1:0] wr_be,
`endif
  input  logic             rd_en,
  input  logic             rd_hit,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [D_W-1:0]   rd_data
);

  logic [D_W-1:0] mem [NUM];

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      // NOTE: the storage must read back as zero after reset, so every word is
      // cleared here; this keeps the array out of dedicated RAM macros.
      for (int i = 0; i < NUM; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      // NOTE: non-blocking assignments make a same-edge read see the old word.
      if (wr_en) begin
`ifdef SLAVE_AXILITE_WSTRB_EN
        for (int b = 0; b < D_W/8; b++)
          if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
`else
        mem[wr_idx] <= wr_data;
`endif
      end
      if (rd_en) rd_data <= rd_hit ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/slave_axilite.sv
// AXI-Lite responder backed by a word register file, all outputs registered.
// Optional byte strobes are enabled by defining SLAVE_AXILITE_WSTRB_EN.
module slave_axilite
  import slave_axilite_pkg::*;
#(
  parameter int                    PARAM_A_W            = 32,
  parameter int                    PARAM_D_W            = 32,
  parameter logic [ADDR_EXT_W-1:0] S_AXILITE_START_ADDR = 'h1000,
  parameter int unsigned           S_AXILITE_NUM_ADDR   = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic [PARAM_A_W-1:0]   M_LITE_W_ADDRESS,
  input  logic                   M_LITE_W_ADDRESS_VALID,
  output logic                   S_LITE_W_ADDRESS_READY,
  input  logic [PARAM_D_W-1:0]   M_LITE_W_DATA,
`ifdef SLAVE_AXILITE_WSTRB_EN
  input  logic [PARAM_D_W/8-1:0] M_LITE_W_STRB,
`endif
  input  logic                   M_LITE_W_DATA_VALID,
  output logic                   S_LITE_W_DATA_READY,
  output logic [1:0]             S_LITE_W_ACK,
  output logic                   S_LITE_W_ACK_VALID,
  input  logic                   M_LITE_W_ACK_READY,
  input  logic [PARAM_A_W-1:0]   M_LITE_R_ADDRESS,
  input  logic                   M_LITE_R_ADDRESS_VALID,
  output logic                   S_LITE_R_ADDRESS_READY,
  output logic [PARAM_D_W-1:0]   S_LITE_R_DATA,
  output logic [1:0]             S_LITE_R_ACK,
  output logic                   S_LITE_R_ACK_VALID,
  input  logic                   M_LITE_R_ACK_READY
);

  localparam int IDX_W = (S_AXILITE_NUM_ADDR > 1) ? $clog2(S_AXILITE_NUM_ADDR) : 1;

  w_state_t              w_state, w_next;
  r_state_t              r_state, r_next;
  logic [ADDR_EXT_W-1:0] aw_addr_q, w_addr_ext, r_addr_ext;
  logic [PARAM_D_W-1:0]  wd_q, w_data_sel;
  logic                  aw_hs, wd_hs, r_hs, w_commit, w_hit, r_hit;
`ifdef SLAVE_AXILITE_WSTRB_EN
  logic [PARAM_D_W/8-1:0] strb_q, w_strb_sel;
`endif

  assign aw_hs = S_LITE_W_ADDRESS_READY & M_LITE_W_ADDRESS_VALID;
  assign wd_hs = S_LITE_W_DATA_READY & M_LITE_W_DATA_VALID;
  assign r_hs  = S_LITE_R_ADDRESS_READY & M_LITE_R_ADDRESS_VALID;

  // Whichever half arrived first comes from its holding register.
  assign w_addr_ext = (w_state == W_HAVE_ADDR) ? aw_addr_q : ADDR_EXT_W'(M_LITE_W_ADDRESS);
  assign w_data_sel = (w_state == W_HAVE_DATA) ? wd_q : M_LITE_W_DATA;
`ifdef SLAVE_AXILITE_WSTRB_EN
  assign w_strb_sel = (w_state == W_HAVE_DATA) ? strb_q : M_LITE_W_STRB;
`endif
  assign r_addr_ext = ADDR_EXT_W'(M_LITE_R_ADDRESS);

  assign w_hit    = addr_in_range(w_addr_ext, S_AXILITE_START_ADDR, S_AXILITE_NUM_ADDR);
  assign r_hit    = addr_in_range(r_addr_ext, S_AXILITE_START_ADDR, S_AXILITE_NUM_ADDR);
  assign w_commit = (w_state != W_RESP) && (w_next == W_RESP);

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && wd_hs) w_next = W_RESP;
        else if (aw_hs)     w_next = W_HAVE_ADDR;
        else if (wd_hs)     w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (wd_hs) w_next = W_RESP;
      W_HAVE_DATA: if (aw_hs) w_next = W_RESP;
      W_RESP:      if (S_LITE_W_ACK_VALID && M_LITE_W_ACK_READY) w_next = W_IDLE;
      default:     w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (r_hs) r_next = R_DATA;
      R_DATA:  if (S_LITE_R_ACK_VALID && M_LITE_R_ACK_READY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      w_state                <= W_IDLE;
      S_LITE_W_ADDRESS_READY <= 1'b0;
      S_LITE_W_DATA_READY    <= 1'b0;
      S_LITE_W_ACK_VALID     <= 1'b0;
      S_LITE_W_ACK           <= RESP_OKAY;
      aw_addr_q              <= '0;
      wd_q                   <= '0;
`ifdef SLAVE_AXILITE_WSTRB_EN
      strb_q                 <= '0;
`endif
    end else begin
      w_state                <= w_next;
      S_LITE_W_ADDRESS_READY <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
      S_LITE_W_DATA_READY    <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
      S_LITE_W_ACK_VALID     <= (w_next == W_RESP);
      if (aw_hs) aw_addr_q <= ADDR_EXT_W'(M_LITE_W_ADDRESS);
      if (wd_hs) begin
        wd_q   <= M_LITE_W_DATA;
`ifdef SLAVE_AXILITE_WSTRB_EN
        strb_q <= M_LITE_W_STRB;
`endif
      end
      if (w_commit) S_LITE_W_ACK <= w_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_state                <= R_IDLE;
      S_LITE_R_ADDRESS_READY <= 1'b0;
      S_LITE_R_ACK_VALID     <= 1'b0;
      S_LITE_R_ACK           <= RESP_OKAY;
    end else begin
      r_state                <= r_next;
      S_LITE_R_ADDRESS_READY <= (r_next == R_IDLE);
      S_LITE_R_ACK_VALID     <= (r_next == R_DATA);
      if (r_hs) S_LITE_R_ACK <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  slave_axilite_regfile #(
    .NUM   (S_AXILITE_NUM_ADDR),
    .D_W   (PARAM_D_W),
    .IDX_W (IDX_W)
  ) u_regfile (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .wr_en   (w_commit && w_hit),
    .wr_idx  (IDX_W'(w_addr_ext - S_AXILITE_START_ADDR)),
    .wr_data (w_data_sel),
`ifdef SLAVE_AXILITE_WSTRB_EN
    .wr_be   (w_strb_sel),
`endif
    .rd_en   (r_hs),
    .rd_hit  (r_hit),
    .rd_idx  (IDX_W'(r_addr_ext - S_AXILITE_START_ADDR)),
    .rd_data (S_LITE_R_DATA)
  );

endmodule

// File: tb/tb_slave_axilite.sv
// Directed bench for slave_axilite; define SLAVE_AXILITE_WSTRB_EN to also
// exercise byte strobes.
module tb_slave_axilite;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr, wdata, ar_addr;
  logic        aw_valid, wd_valid, b_ready, ar_valid, r_ready;
  logic        aw_ready, wd_ready, b_valid, ar_ready, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] rdata;
`ifdef SLAVE_AXILITE_WSTRB_EN
  logic [3:0]  wstrb;
`endif

  logic [31:0] model [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  slave_axilite dut (
    .axi_clk                (clk),
    .axi_rst                (rst),
    .M_LITE_W_ADDRESS       (aw_addr),
    .M_LITE_W_ADDRESS_VALID (aw_valid),
    .S_LITE_W_ADDRESS_READY (aw_ready),
    .M_LITE_W_DATA          (wdata),
`ifdef SLAVE_AXILITE_WSTRB_EN
    .M_LITE_W_STRB          (wstrb),
`endif
    .M_LITE_W_DATA_VALID    (wd_valid),
    .S_LITE_W_DATA_READY    (wd_ready),
    .S_LITE_W_ACK           (b_resp),
    .S_LITE_W_ACK_VALID     (b_valid),
    .M_LITE_W_ACK_READY     (b_ready),
    .M_LITE_R_ADDRESS       (ar_addr),
    .M_LITE_R_ADDRESS_VALID (ar_valid),
    .S_LITE_R_ADDRESS_READY (ar_ready),
    .S_LITE_R_DATA          (rdata),
    .S_LITE_R_ACK           (r_resp),
    .S_LITE_R_ACK_VALID     (r_valid),
    .M_LITE_R_ACK_READY     (r_ready)
  );

  // Both write halves presented together; called and returns at a negedge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    aw_addr = a; wdata = d; aw_valid = 1'b1; wd_valid = 1'b1; b_ready = 1'b1;
    while (!(aw_ready && wd_ready) && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    aw_valid = 1'b0; wd_valid = 1'b0;
    while (!b_valid && n < TMO) begin @(negedge clk); n++; end
    resp = b_resp;
    @(negedge clk);
    b_ready = 1'b0;
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL write_timeout addr=%h cycles=%0d limit=%0d", a, n, TMO); end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
    while (!ar_ready && n < TMO) begin @(negedge clk); n++; end
    @(negedge clk);
    ar_valid = 1'b0;
    while (!r_valid && n < TMO) begin @(negedge clk); n++; end
    d = rdata; resp = r_resp;
    @(negedge clk);
    r_ready = 1'b0;
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL read_timeout addr=%h cycles=%0d limit=%0d", a, n, TMO); end
  endtask

  task automatic sweep(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 16; i++) begin
      axi_read(32'h1000 + 32'(i), d, r);
      checks++;
      if ({d, r} !== {model[i], 2'b00})
        begin errors++; $display("FAIL %s reg%0d got data=%h resp=%b exp data=%h resp=00", tag, i, d, r, model[i]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({aw_ready, wd_ready, ar_ready, b_valid, r_valid} !== 5'b0)
      begin errors++; $display("FAIL reset_handshake got %b exp 00000", {aw_ready, wd_ready, ar_ready, b_valid, r_valid}); end
    checks++;
    if ({b_resp, r_resp, rdata} !== 36'h0)
      begin errors++; $display("FAIL reset_payload got b=%b r=%b d=%h exp 0", b_resp, r_resp, rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({aw_ready, wd_ready, ar_ready} !== 3'b111)
      begin errors++; $display("FAIL reset_release_ready got %b exp 111", {aw_ready, wd_ready, ar_ready}); end
  endtask

  task automatic test_same_edge_write();
    logic [31:0] d;
    logic [1:0]  r;
    aw_addr = 32'h1003; wdata = 32'hDEADBEEF; aw_valid = 1'b1; wd_valid = 1'b1; b_ready = 1'b0;
    @(negedge clk);
    aw_valid = 1'b0; wd_valid = 1'b0;
    checks++;
    if ({b_valid, b_resp, aw_ready, wd_ready} !== 5'b1_00_00)
      begin errors++; $display("FAIL same_edge_ack got v=%b resp=%b rdy=%b%b exp v=1 resp=00 rdy=00", b_valid, b_resp, aw_ready, wd_ready); end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    checks++;
    if ({b_valid, aw_ready, wd_ready} !== 3'b011)
      begin errors++; $display("FAIL same_edge_idle got %b exp 011", {b_valid, aw_ready, wd_ready}); end
    model[3] = 32'hDEADBEEF;
    axi_read(32'h1003, d, r);
    checks++;
    if ({d, r} !== {32'hDEADBEEF, 2'b00})
      begin errors++; $display("FAIL same_edge_readback got %h/%b exp deadbeef/00", d, r); end
  endtask

  task automatic test_addr_first();
    logic [31:0] d;
    logic [1:0]  r;
    aw_addr = 32'h1000; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({aw_ready, wd_ready, b_valid} !== 3'b010)
        begin errors++; $display("FAIL have_addr_hold cyc%0d got %b exp 010", i, {aw_ready, wd_ready, b_valid}); end
      @(negedge clk);
    end
    wdata = 32'h12345678; wd_valid = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    wd_valid = 1'b0;
    checks++;
    if ({b_valid, b_resp} !== 3'b1_00)
      begin errors++; $display("FAIL addr_first_ack got v=%b resp=%b exp v=1 resp=00", b_valid, b_resp); end
    @(negedge clk);
    b_ready = 1'b0;
    model[0] = 32'h12345678;
    axi_read(32'h1000, d, r);
    checks++;
    if ({d, r} !== {32'h12345678, 2'b00})
      begin errors++; $display("FAIL addr_first_readback got %h/%b exp 12345678/00", d, r); end
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h2000, 32'hCAFEF00D, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL slverr_write got %b exp 10", r); end
    axi_read(32'h0FFF, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b10})
      begin errors++; $display("FAIL slverr_read got %h/%b exp 00000000/10", d, r); end
    sweep("slverr_sweep");
  endtask

  task automatic test_backpressure();
    aw_addr = 32'h1001; wdata = 32'h11112222; aw_valid = 1'b1; wd_valid = 1'b1; b_ready = 1'b0;
    ar_addr = 32'h1003; ar_valid = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    aw_valid = 1'b0; wd_valid = 1'b0; ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // A second pending request on every channel must not be taken.
      aw_valid = 1'b1; wd_valid = 1'b1; ar_valid = 1'b1; ar_addr = 32'h1000;
      checks++;
      if ({b_valid, b_resp, aw_ready, wd_ready} !== 5'b1_00_00)
        begin errors++; $display("FAIL bp_write cyc%0d got v=%b resp=%b rdy=%b%b exp 1/00/00", i, b_valid, b_resp, aw_ready, wd_ready); end
      checks++;
      if ({r_valid, r_resp, rdata, ar_ready} !== {1'b1, 2'b00, 32'hDEADBEEF, 1'b0})
        begin errors++; $display("FAIL bp_read cyc%0d got v=%b resp=%b d=%h rdy=%b exp 1/00/deadbeef/0", i, r_valid, r_resp, rdata, ar_ready); end
      @(negedge clk);
    end
    aw_valid = 1'b0; wd_valid = 1'b0; ar_valid = 1'b0;
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    checks++;
    if ({b_valid, r_valid, aw_ready, wd_ready, ar_ready} !== 5'b00111)
      begin errors++; $display("FAIL bp_release got %b exp 00111", {b_valid, r_valid, aw_ready, wd_ready, ar_ready}); end
    model[1] = 32'h11112222;
  endtask

  task automatic test_same_edge_rw();
    logic [31:0] d;
    logic [1:0]  r;
    aw_addr = 32'h1005; wdata = 32'hA5A5A5A5; aw_valid = 1'b1; wd_valid = 1'b1; b_ready = 1'b1;
    ar_addr = 32'h1005; ar_valid = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; wd_valid = 1'b0; ar_valid = 1'b0;
    checks++;
    if ({r_valid, rdata, b_valid} !== {1'b1, 32'h0, 1'b1})
      begin errors++; $display("FAIL rw_collision got rv=%b d=%h bv=%b exp 1/00000000/1", r_valid, rdata, b_valid); end
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    model[5] = 32'hA5A5A5A5;
    axi_read(32'h1005, d, r);
    checks++;
    if ({d, r} !== {32'hA5A5A5A5, 2'b00})
      begin errors++; $display("FAIL rw_followup got %h/%b exp a5a5a5a5/00", d, r); end
  endtask

  task automatic test_reset_mid();
    aw_addr = 32'h1002; wdata = 32'h55555555; aw_valid = 1'b1; wd_valid = 1'b1; b_ready = 1'b0;
    ar_addr = 32'h1000; ar_valid = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    aw_valid = 1'b0; wd_valid = 1'b0; ar_valid = 1'b0;
    checks++;
    if ({b_valid, r_valid} !== 2'b11)
      begin errors++; $display("FAIL mid_pending got %b exp 11", {b_valid, r_valid}); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_valid, r_valid, aw_ready, wd_ready, ar_ready} !== 5'b0)
      begin errors++; $display("FAIL mid_reset_drop got %b exp 00000", {b_valid, r_valid, aw_ready, wd_ready, ar_ready}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    sweep("mid_reset_sweep");
  endtask

`ifdef SLAVE_AXILITE_WSTRB_EN
  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    wstrb = 4'b0011;
    axi_write(32'h1006, 32'hFFFFFFFF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb_write_resp got %b exp 00", r); end
    axi_read(32'h1006, d, r);
    checks++;
    if ({d, r} !== {32'h0000FFFF, 2'b00})
      begin errors++; $display("FAIL strb_partial got %h/%b exp 0000ffff/00", d, r); end
    wstrb = 4'b0000;
    axi_write(32'h1007, 32'hFFFFFFFF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb_zero_resp got %b exp 00", r); end
    axi_read(32'h1007, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b00})
      begin errors++; $display("FAIL strb_zero_data got %h/%b exp 00000000/00", d, r); end
    wstrb = 4'hF;
  endtask
`endif

  initial begin
    aw_addr = '0; wdata = '0; ar_addr = '0;
    aw_valid = 1'b0; wd_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
`ifdef SLAVE_AXILITE_WSTRB_EN
    wstrb = 4'hF;
`endif
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_same_edge_write();
    test_addr_first();
    test_slverr();
    test_backpressure();
    test_same_edge_rw();
    test_reset_mid();
`ifdef SLAVE_AXILITE_WSTRB_EN
    test_strobe();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slave_axilite.md
# slave_axilite

AXI-Lite responder that terminates the AXI-Lite bus driven by `master_axilite` and backs it with a small word-addressed register file. It accepts write address and write data independently, commits the write, and returns a write response. It accepts read addresses and returns data plus a read response. It replaces the behavioural slave model in the bench so the master can be checked against synthesizable RTL.

## Interface
- `PARAM_A_W`, 32: address width.
- `PARAM_D_W`, 32: data width.
- `S_AXILITE_START_ADDR`, 'h1000: first valid address.
- `S_AXILITE_NUM_ADDR`, 16: number of word registers. Address N maps to register N − START.
- `axi_clk  in  1`: single clock. All logic is on its rising edge.
- `axi_rst  in  1`: synchronous, active-high reset.
- `M_LITE_W_ADDRESS  in  PARAM_A_W`, `M_LITE_W_ADDRESS_VALID  in  1`, `S_LITE_W_ADDRESS_READY  out  1`: write address channel.
- `M_LITE_W_DATA  in  PARAM_D_W`, `M_LITE_W_DATA_VALID  in  1`, `S_LITE_W_DATA_READY  out  1`: write data channel.
- `S_LITE_W_ACK  out  2`, `S_LITE_W_ACK_VALID  out  1`, `M_LITE_W_ACK_READY  in  1`: write response channel.
- `M_LITE_R_ADDRESS  in  PARAM_A_W`, `M_LITE_R_ADDRESS_VALID  in  1`, `S_LITE_R_ADDRESS_READY  out  1`: read address channel.
- `S_LITE_R_DATA  out  PARAM_D_W`, `S_LITE_R_ACK  out  2`, `S_LITE_R_ACK_VALID  out  1`, `M_LITE_R_ACK_READY  in  1`: read data/response channel.

## Operation
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- An address is in range when START ≤ addr ≤ START + NUM − 1. Comparison uses full `PARAM_A_W` width with no truncation.
- Write FSM has four states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: both write readies are 1.
  - An address handshake alone goes to W_HAVE_ADDR. A data handshake alone goes to W_HAVE_DATA. Both on the same edge go straight to W_RESP.
  - W_HAVE_ADDR: only DATA_READY is 1. A data handshake goes to W_RESP.
  - W_HAVE_DATA: only ADDRESS_READY is 1. An address handshake goes to W_RESP.
  - The write commits on the edge that completes the pair. Out-of-range writes are discarded and return SLVERR.
  - W_RESP: both readies are 0 and W_ACK_VALID is 1. When ACK_READY is seen, go to W_IDLE.
- Read FSM has two states: R_IDLE, R_DATA.
  - R_IDLE: ADDRESS_READY is 1. A handshake captures data and response and goes to R_DATA.
  - R_DATA: ADDRESS_READY is 0 and R_ACK_VALID is 1. When ACK_READY is seen, go to R_IDLE.
  - Out-of-range reads return data 0 and SLVERR.
- Read and write channels are fully independent and may overlap.
- Same-edge write commit and read capture to the same register: the read returns the pre-write value.
- VALID-held payloads (ACK, R_DATA) stay stable until accepted.

## Timing
- All outputs are registered.
- Reset values:
  - All READYs 0. All VALIDs 0. `S_LITE_W_ACK` and `S_LITE_R_ACK` are 0. `S_LITE_R_DATA` is 0.
  - Registers are cleared to 0.
  - First cycle after reset deasserts: READYs go to 1.
- Write latency: completion handshake at edge N gives W_ACK_VALID = 1 from edge N onward.
- Read latency: address handshake at edge N gives R_ACK_VALID = 1 and data valid from edge N onward.
- A VALID with ACK_READY already 1 is accepted on the first cycle. At least one idle cycle (READY re-asserted) follows each response.
- Reset mid-transaction: both FSMs return to idle, pending responses are dropped, and VALIDs drop on that edge.

## Configuration
- `SLAVE_AXILITE_WSTRB_EN` defined:
  - Adds port `M_LITE_W_STRB  in  PARAM_D_W/8`, captured with the write data.
  - Only bytes whose strobe bit is 1 are updated.
  - Strobe 0 with an in-range address returns OKAY and leaves the register unchanged.
- Undefined: the port is absent and all bytes are written.

## Structure
- `slave_axilite_pkg` holds:
  - the response-code constants;
  - the `w_state_t` and `r_state_t` enums;
  - an in-range check function parameterised by START/NUM.
- One sub-module, `slave_axilite_regfile`:
  - NUM × D_W registers;
  - one synchronous write port (with byte enables under the macro);
  - one read port registered on read capture;
  - synchronous clear on `axi_rst`.

## Test plan
- Write 'h1003 / 'hDEADBEEF with both VALIDs on the same edge, then read 'h1003 → W_ACK 2'b00 one cycle later; read returns 'hDEADBEEF with R_ACK 2'b00.
- Address first, data three cycles later (write 'h1000 / 'h12345678) → readies hold in W_HAVE_ADDR; ack follows the data edge by one cycle; readback matches.
- Write 'h2000 and read 'h0FFF → SLVERR on both; read data 0; no register changes (full sweep of 'h1000–'h100F is unchanged).
- Hold ACK_READY low for 5 cycles on both channels → VALID and payloads stay stable; ADDRESS_READY stays 0 throughout.
- Same-edge write 'h1005 = 'hA5A5A5A5 and read 'h1005 (old value 0) → read returns 0; a subsequent read returns 'hA5A5A5A5.
- Assert `axi_rst` while in W_RESP and R_DATA → VALIDs 0 on that edge; all registers read back 0 after reset.
  - With the macro defined, strobe 4'b0011 writing 'hFFFFFFFF over 0 → reads back 'h0000FFFF.
